// File: rtl/demux_1x4_buffered.sv
// Registered 1-to-4 demultiplexer with one holding register per output.
// Each slot is filled by the producer and drained by its own consumer.
module demux_1x4_buffered #(
  parameter int DATA_WIDTH = 32
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic [1:0]            selector,
  input  logic [DATA_WIDTH-1:0] data_in,
  input  logic                  in_valid,
  output logic                  in_ready,
  output logic [DATA_WIDTH-1:0] data_out_0,
  output logic [DATA_WIDTH-1:0] data_out_1,
  output logic [DATA_WIDTH-1:0] data_out_2,
  output logic [DATA_WIDTH-1:0] data_out_3,
  output logic [3:0]            out_valid,
  input  logic [3:0]            out_ready
);

  logic [3:0]            full_q;
  logic [3:0]            load;
  logic [3:0]            drain;
  logic [DATA_WIDTH-1:0] slot_q [4];

  assign out_valid  = full_q;
  assign data_out_0 = slot_q[0];
  assign data_out_1 = slot_q[1];
  assign data_out_2 = slot_q[2];
  assign data_out_3 = slot_q[3];

  // Selected slot can take a word if empty or being drained this edge.
  assign in_ready = ~reset
                  & (~full_q[selector] | out_ready[selector]);

  // One-hot load of the selected slot and per-slot drain strobes.
  always_comb begin
    load  = '0;
    drain = full_q & out_ready;
    if (in_valid && in_ready) begin
      unique case (selector)
        2'd0: load[0] = 1'b1;
        2'd1: load[1] = 1'b1;
        2'd2: load[2] = 1'b1;
        2'd3: load[3] = 1'b1;
        default: load = '0;
      endcase
    end
  end

  // Full flags: a refill on the draining edge keeps the slot full.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      full_q <= '0;
    end else begin
      full_q <= (full_q & ~drain) | load;
    end
  end

  // Data registers only change on load; drained slots keep stale data.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      for (int k = 0; k < 4; k++) begin
        slot_q[k] <= '0;
      end
    end else begin
      for (int k = 0; k < 4; k++) begin
        if (load[k]) begin
          slot_q[k] <= data_in;
        end
      end
    end
  end

endmodule

// File: doc/demux_1x4_buffered.md
# demux_1x4_buffered

Registered 1-to-4 demultiplexer with per-output valid/ready handshake, the distribution counterpart of the datapath's 4:1 operand/result select. It accepts one 32-bit word per cycle and a 2-bit selector, and steers the word into one of four single-entry output holding registers. Each register is drained independently by its consumer, such as a writeback port, forwarding path or memory staging slot. The block lets one producer feed four consumers without dropping data when a consumer stalls.

## Interface
- DATA_WIDTH, 32, width of data word and every output register

- clk  input  1  rising-edge clock
- reset  input  1  asynchronous, active-high; clears all state immediately
- selector  input  2  destination slot for the word on data_in (00→0, 01→1, 10→2, 11→3)
- data_in  input  DATA_WIDTH  word to route
- in_valid  input  1  producer presents data_in/selector this cycle
- in_ready  output  1  block accepts data_in this cycle
- data_out_0..data_out_3  output  DATA_WIDTH each  holding register contents of slot k
- out_valid  output  4  bit k: slot k holds an undelivered word
- out_ready  input  4  bit k: consumer k takes slot k this cycle

## Operation
- State: four data registers `data_out_k` and four full flags. `out_valid[k]` = full flag k, driven directly from the flop.
- `in_ready` = ~reset & (~out_valid[selector] | out_ready[selector]). This is combinational on selector/out_ready/state and never depends on in_valid.
- Accept: in_valid & in_ready at a rising edge. data_in loads into `data_out_[selector]`, and that slot's flag sets.
- Drain: out_valid[k] & out_ready[k] at a rising edge. Slot k's flag clears unless the same edge accepts a new word into slot k, in which case the flag stays 1 and the register holds the new word.
- Slots are independent. Any subset may drain on the same edge as an accept into any slot.
- out_ready[k] while out_valid[k]=0 has no effect.
- A slot that is not accepted this cycle keeps its data register unchanged. A drained slot keeps its stale data (data_out_k is not cleared). Consumers must qualify data with out_valid.
- selector and data_in are don't-care when in_valid=0. No state changes in that case, apart from drains.
- No ordering between slots is guaranteed or tracked. Within one slot, words deliver in acceptance order, and at most one is outstanding.
- Reset asserted at any time, including mid-transfer, does the following:
  - clears all flags and data registers to 0 asynchronously;
  - forces in_ready=0 for as long as reset is high;
  - drops any in-flight word, with no partial update.
- First accept is possible on the first rising edge after reset deasserts.

## Timing
- Reset values: out_valid=4'b0000, data_out_0..3=0, in_ready=0 while reset=1.
- Latency: a word accepted at edge N is visible on data_out_k with out_valid[k]=1 immediately after edge N, i.e. in the following cycle. This is 1 cycle.
- Throughput: 1 word/cycle aggregate. It is sustained into a single slot when its consumer holds out_ready=1, via same-edge drain and refill.
- Backpressure: slot k full and out_ready[k]=0 → in_ready=0 whenever selector=k. Other selectors are unaffected (no head-of-line blocking beyond the presented word).
- Producer rule: once in_valid=1 with in_ready=0, the producer holds in_valid, selector and data_in stable until accepted.
- Consumer rule: out_valid[k] and data_out_k stay stable until the edge where out_ready[k]=1.
- Combinational paths: out_ready→in_ready and selector→in_ready only. No path from in_valid or data_in to any output.

## Test plan
- Reset/defaults: hold reset 3 cycles with in_valid=1 → in_ready=0, out_valid=0000, all data_out=0. Assert reset mid-stream with slots 1 and 3 full → out_valid=0000 immediately, before the next edge.
- Basic routing: out_ready=0000; send 0xA0000000..0xA0000003 to selectors 0,1,2,3 on consecutive cycles → each in_ready=1, and one cycle after its accept out_valid has the corresponding bit set (0001, 0011, 0111, 1111); data_out_k=0xA000000k.
- Backpressure: slot 2 full, out_ready=0000, present 0xDEADBEEF to selector 2 for 4 cycles → in_ready=0 throughout, data_out_2 unchanged. Raise out_ready[2] → accept on that edge, data_out_2=0xDEADBEEF, out_valid[2] stays 1.
- Non-blocking: slot 0 full and stalled; send 0x11111111 to selector 3 → accepted immediately, out_valid=1001.
- Streaming: out_ready=1111, 16 back-to-back words to selector 1 with values 0..15 → in_ready=1 every cycle, out_valid[1]=1 continuously, consumer sees 0..15 in order with no gaps.
- Stale data: drain slot 0 holding 0x5 → out_valid[0]=0, data_out_0 still 0x5. out_ready[0]=1 with no valid → no change.
